ccip_mmio_csr: RTL and testbench

MMIO CSR endpoint that sits directly downstream of the CCI-P emulator's Rx channel 0 and upstream of its Tx channel 2, inside the AFU. It decodes MMIO read/write requests, holds the AFU's device feature header, ID, scratch, counter and control/status registers, and returns pipelined MMIO read responses with the request's transaction ID. It also emits a one-cycle start pulse to AFU datapath logic and counts malformed requests.

---
 rtl/ccip_mmio_csr.sv | 168 ++++++++++++++++
 tb/tb_ccip_mmio_csr.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ccip_mmio_csr.sv
// CCI-P MMIO CSR endpoint: decodes c0 MMIO requests, holds DFH/ID/scratch/counter/status, returns c2 read responses.
// Optional MMIO_RSP_REG_EN adds an output register stage on tx_mmio_rsp_* (read latency 3 instead of 2).
module ccip_mmio_csr #(
    parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_1000,
    parameter logic [63:0] AFU_ID_L  = 64'h0,
    parameter logic [63:0] AFU_ID_H  = 64'h0
) (
    input  logic        pClk,
    input  logic        pck_cp2af_softReset,
    input  logic        rx_mmio_rd_valid,
    input  logic        rx_mmio_wr_valid,
    input  logic [15:0] rx_mmio_addr,
    input  logic [1:0]  rx_mmio_len,
    input  logic [8:0]  rx_mmio_tid,
    input  logic [63:0] rx_data,
    input  logic [31:0] afu_status_in,
    output logic        tx_mmio_rsp_valid,
    output logic [8:0]  tx_mmio_rsp_tid,
    output logic [63:0] tx_mmio_rsp_data,
    output logic        start_pulse
);
    localparam logic [2:0] REG_DFH     = 3'd0;
    localparam logic [2:0] REG_ID_L    = 3'd1;
    localparam logic [2:0] REG_ID_H    = 3'd2;
    localparam logic [2:0] REG_SCRATCH = 3'd3;
    localparam logic [2:0] REG_CYCLE   = 3'd4;
    localparam logic [2:0] REG_CTRL    = 3'd5;
    localparam logic [2:0] REG_STATUS  = 3'd6;

    logic        srst;
    logic        len8, len_err, align_err, any_err, wr_ok, rd_ok, mapped, ctrl_hit, scratch_hit;
    logic [2:0]  reg_idx;
    logic [63:0] scratch_val;
    logic [63:0] cycle_cnt_reg;
    logic [15:0] err_cnt_reg;
    logic        start_pulse_reg;

    assign srst      = pck_cp2af_softReset;
    assign len8      = (rx_mmio_len == 2'd1);
    assign len_err   = rx_mmio_len[1];
    assign align_err = len8 && rx_mmio_addr[0];
    assign any_err   = ((rx_mmio_rd_valid || rx_mmio_wr_valid) && (len_err || align_err))
                     || (rx_mmio_rd_valid && rx_mmio_wr_valid);
    assign wr_ok     = rx_mmio_wr_valid && !len_err && !align_err;
    // A simultaneous write wins; the read half of the pair is dropped.
    assign rd_ok     = rx_mmio_rd_valid && !rx_mmio_wr_valid;
    assign mapped    = (rx_mmio_addr[15:4] == 12'd0);
    assign reg_idx   = rx_mmio_addr[3:1];
    assign ctrl_hit  = wr_ok && mapped && (reg_idx == REG_CTRL) && !rx_mmio_addr[0];
    assign scratch_hit = wr_ok && mapped && (reg_idx == REG_SCRATCH);

    // Each SCRATCH DW half is written by an 8 B write or a 4 B write addressing it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_scratch
        logic [31:0] half_reg;
        always_ff @(posedge pClk) begin
            if (srst) begin
                half_reg <= 32'h0;
            end else if (scratch_hit && (len8 || (rx_mmio_addr[0] == gi[0]))) begin
                half_reg <= len8 ? rx_data[gi*32 +: 32] : rx_data[31:0];
            end
        end
    end
    assign scratch_val = {g_scratch[1].half_reg, g_scratch[0].half_reg};

    always_ff @(posedge pClk) begin
        if (srst) begin
            cycle_cnt_reg   <= 64'h0;
            err_cnt_reg     <= 16'h0;
            start_pulse_reg <= 1'b0;
        end else begin
            cycle_cnt_reg   <= cycle_cnt_reg + 64'd1;
            start_pulse_reg <= ctrl_hit && rx_data[0];
            if (ctrl_hit && rx_data[1]) begin
                err_cnt_reg <= 16'h0;
            end else if (any_err && (err_cnt_reg != 16'hFFFF)) begin
                err_cnt_reg <= err_cnt_reg + 16'd1;
            end
        end
    end
    assign start_pulse = start_pulse_reg;

    // Stage 1: capture decode, TID and the counter snapshot.
    logic        s1_valid_reg, s1_half_reg, s1_len8_reg, s1_zero_reg;
    logic [8:0]  s1_tid_reg;
    logic [2:0]  s1_idx_reg;
    logic [63:0] s1_cycle_reg;

    always_ff @(posedge pClk) begin
        if (srst) begin
            s1_valid_reg <= 1'b0;
            s1_tid_reg   <= 9'h0;
            s1_idx_reg   <= 3'd0;
            s1_half_reg  <= 1'b0;
            s1_len8_reg  <= 1'b0;
            s1_zero_reg  <= 1'b0;
            s1_cycle_reg <= 64'h0;
        end else begin
            s1_valid_reg <= rd_ok;
            s1_tid_reg   <= rx_mmio_tid;
            s1_idx_reg   <= reg_idx;
            s1_half_reg  <= rx_mmio_addr[0];
            s1_len8_reg  <= len8;
            s1_zero_reg  <= len_err || align_err || !mapped;
            s1_cycle_reg <= cycle_cnt_reg;
        end
    end

    // Stage 2: register-select mux and DW replication.
    logic [63:0] raw_next, rd_data_next;
    logic [31:0] dw_next;

    always_comb begin
        raw_next = 64'h0;
        case (s1_idx_reg)
            REG_DFH:     raw_next = DFH_VALUE;
            REG_ID_L:    raw_next = AFU_ID_L;
            REG_ID_H:    raw_next = AFU_ID_H;
            REG_SCRATCH: raw_next = scratch_val;
            REG_CYCLE:   raw_next = s1_cycle_reg;
            REG_STATUS:  raw_next = {16'h0, err_cnt_reg, afu_status_in};
            default:     raw_next = 64'h0;
        endcase
        dw_next      = s1_half_reg ? raw_next[63:32] : raw_next[31:0];
        rd_data_next = s1_zero_reg ? 64'h0 : (s1_len8_reg ? raw_next : {dw_next, dw_next});
    end

    logic        s2_valid_reg;
    logic [8:0]  s2_tid_reg;
    logic [63:0] s2_data_reg;

    always_ff @(posedge pClk) begin
        if (srst) begin
            s2_valid_reg <= 1'b0;
            s2_tid_reg   <= 9'h0;
            s2_data_reg  <= 64'h0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            s2_tid_reg   <= s1_tid_reg;
            s2_data_reg  <= rd_data_next;
        end
    end

`ifdef MMIO_RSP_REG_EN
    logic        s3_valid_reg;
    logic [8:0]  s3_tid_reg;
    logic [63:0] s3_data_reg;

    always_ff @(posedge pClk) begin
        if (srst) begin
            s3_valid_reg <= 1'b0;
            s3_tid_reg   <= 9'h0;
            s3_data_reg  <= 64'h0;
        end else begin
            s3_valid_reg <= s2_valid_reg;
            s3_tid_reg   <= s2_tid_reg;
            s3_data_reg  <= s2_data_reg;
        end
    end
    assign tx_mmio_rsp_valid = s3_valid_reg;
    assign tx_mmio_rsp_tid   = s3_tid_reg;
    assign tx_mmio_rsp_data  = s3_data_reg;
`else
    assign tx_mmio_rsp_valid = s2_valid_reg;
    assign tx_mmio_rsp_tid   = s2_tid_reg;
    assign tx_mmio_rsp_data  = s2_data_reg;
`endif

endmodule

// File: tb/tb_ccip_mmio_csr.sv
// Self-checking bench for ccip_mmio_csr: vector table plus scoreboard of expected read responses.
module tb_ccip_mmio_csr;
`ifdef MMIO_RSP_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam logic [63:0] DFH  = 64'h1000_0000_0000_1000;
    localparam logic [63:0] IDL  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] IDH  = 64'hFEDC_BA98_7654_3210;
    localparam logic [31:0] STAT = 32'hA5A5_0001;

    logic        pClk = 1'b0;
    logic        pck_cp2af_softReset = 1'b1;
    logic        rx_mmio_rd_valid = 1'b0;
    logic        rx_mmio_wr_valid = 1'b0;
    logic [15:0] rx_mmio_addr = 16'h0;
    logic [1:0]  rx_mmio_len = 2'd0;
    logic [8:0]  rx_mmio_tid = 9'h0;
    logic [63:0] rx_data = 64'h0;
    logic [31:0] afu_status_in = STAT;
    logic        tx_mmio_rsp_valid;
    logic [8:0]  tx_mmio_rsp_tid;
    logic [63:0] tx_mmio_rsp_data;
    logic        start_pulse;

    ccip_mmio_csr #(.DFH_VALUE(DFH), .AFU_ID_L(IDL), .AFU_ID_H(IDH)) dut (
        .pClk(pClk), .pck_cp2af_softReset(pck_cp2af_softReset),
        .rx_mmio_rd_valid(rx_mmio_rd_valid), .rx_mmio_wr_valid(rx_mmio_wr_valid),
        .rx_mmio_addr(rx_mmio_addr), .rx_mmio_len(rx_mmio_len), .rx_mmio_tid(rx_mmio_tid),
        .rx_data(rx_data), .afu_status_in(afu_status_in),
        .tx_mmio_rsp_valid(tx_mmio_rsp_valid), .tx_mmio_rsp_tid(tx_mmio_rsp_tid),
        .tx_mmio_rsp_data(tx_mmio_rsp_data), .start_pulse(start_pulse)
    );

    always #5 pClk = ~pClk;

    int cyc = 0;
    always @(posedge pClk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        logic        chk;
        int          due;
    } sb_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  len;
        logic [8:0]  tid;
        logic [63:0] wdata;
        logic        exp;
        logic [63:0] edata;
    } vec_t;

    sb_t         exp_q[$];
    logic [63:0] cap_q[$];
    sb_t         mon_e;
    vec_t        vecs[27];
    int checks = 0;
    int errors = 0;
    int unexpected = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Response monitor: pops the scoreboard and checks TID, data and arrival cycle.
    always @(negedge pClk) begin
        if (tx_mmio_rsp_valid) begin
            if (exp_q.size() == 0) begin
                errors++;
                unexpected++;
                $display("FAIL unexpected_rsp actual tid=%h data=%h required no response",
                         tx_mmio_rsp_tid, tx_mmio_rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                $display("RSP cyc=%0d tid=%h data=%h", cyc, tx_mmio_rsp_tid, tx_mmio_rsp_data);
                check("rsp_tid", 64'(tx_mmio_rsp_tid), 64'(mon_e.tid));
                check("rsp_cycle", 64'(cyc), 64'(mon_e.due));
                if (mon_e.chk) check("rsp_data", tx_mmio_rsp_data, mon_e.data);
                else cap_q.push_back(tx_mmio_rsp_data);
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [1:0] len, input logic [8:0] tid, input logic [63:0] wdata,
                         input logic exp, input logic chk, input logic [63:0] edata);
        @(posedge pClk); #1;
        rx_mmio_rd_valid = rd;
        rx_mmio_wr_valid = wr;
        rx_mmio_addr     = addr;
        rx_mmio_len      = len;
        rx_mmio_tid      = tid;
        rx_data          = wdata;
        if (exp) exp_q.push_back('{tid: tid, data: edata, chk: chk, due: cyc + LAT});
    endtask

    task automatic idle();
        @(posedge pClk); #1;
        rx_mmio_rd_valid = 1'b0;
        rx_mmio_wr_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge pClk);
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=expired required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1, 0, 16'h00, 2'd1, 9'h1A5, 64'h0, 1, DFH};
        vecs[1]  = '{0, 1, 16'h06, 2'd1, 9'h000, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'h0};
        vecs[2]  = '{0, 1, 16'h07, 2'd0, 9'h000, 64'h0000_0000_1234_5678, 0, 64'h0};
        vecs[3]  = '{1, 0, 16'h06, 2'd1, 9'h010, 64'h0, 1, 64'h1234_5678_CAFE_F00D};
        vecs[4]  = '{1, 0, 16'h06, 2'd0, 9'h011, 64'h0, 1, 64'hCAFE_F00D_CAFE_F00D};
        vecs[5]  = '{1, 0, 16'h07, 2'd0, 9'h012, 64'h0, 1, 64'h1234_5678_1234_5678};
        vecs[6]  = '{1, 0, 16'h00, 2'd1, 9'h001, 64'h0, 1, DFH};
        vecs[7]  = '{1, 0, 16'h02, 2'd1, 9'h002, 64'h0, 1, IDL};
        vecs[8]  = '{1, 0, 16'h04, 2'd1, 9'h003, 64'h0, 1, IDH};
        vecs[9]  = '{1, 0, 16'h10, 2'd1, 9'h004, 64'h0, 1, 64'h0};
        vecs[10] = '{1, 0, 16'h0A, 2'd1, 9'h020, 64'h0, 1, 64'h0};
        vecs[11] = '{1, 0, 16'h0E, 2'd1, 9'h021, 64'h0, 1, 64'h0};
        vecs[12] = '{1, 0, 16'h01, 2'd0, 9'h022, 64'h0, 1, 64'h1000_0000_1000_0000};
        vecs[13] = '{1, 0, 16'h03, 2'd1, 9'h055, 64'h0, 1, 64'h0};
        vecs[14] = '{1, 0, 16'h00, 2'd3, 9'h056, 64'h0, 1, 64'h0};
        vecs[15] = '{1, 1, 16'h06, 2'd1, 9'h057, 64'h1111, 0, 64'h0};
        vecs[16] = '{1, 0, 16'h06, 2'd1, 9'h058, 64'h0, 1, 64'h1111};
        vecs[17] = '{1, 0, 16'h0C, 2'd1, 9'h059, 64'h0, 1, {32'h3, STAT}};
        vecs[18] = '{0, 1, 16'h0A, 2'd1, 9'h000, 64'h2, 0, 64'h0};
        vecs[19] = '{1, 0, 16'h0C, 2'd1, 9'h05A, 64'h0, 1, {32'h0, STAT}};
        vecs[20] = '{0, 1, 16'h16, 2'd1, 9'h000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0};
        vecs[21] = '{1, 0, 16'h06, 2'd1, 9'h05B, 64'h0, 1, 64'h1111};
        vecs[22] = '{0, 1, 16'h07, 2'd1, 9'h000, 64'h0, 0, 64'h0};
        vecs[23] = '{1, 0, 16'h06, 2'd1, 9'h05C, 64'h0, 1, 64'h1111};
        vecs[24] = '{1, 0, 16'h0C, 2'd1, 9'h05D, 64'h0, 1, {32'h1, STAT}};
        vecs[25] = '{1, 0, 16'h11, 2'd0, 9'h05E, 64'h0, 1, 64'h0};
        vecs[26] = '{1, 0, 16'h0D, 2'd0, 9'h05F, 64'h0, 1, 64'h0000_0001_0000_0001};

        repeat (3) @(posedge pClk);
        @(negedge pClk);
        check("reset_rsp_valid", 64'(tx_mmio_rsp_valid), 64'd0);
        check("reset_rsp_tid", 64'(tx_mmio_rsp_tid), 64'd0);
        check("reset_rsp_data", tx_mmio_rsp_data, 64'd0);
        check("reset_start_pulse", 64'(start_pulse), 64'd0);
        @(posedge pClk); #1;
        pck_cp2af_softReset = 1'b0;

        for (int i = 0; i < 27; i++)
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].tid,
                  vecs[i].wdata, vecs[i].exp, 1'b1, vecs[i].edata);
        idle();
        drain();

        // start_pulse: only a low-DW CTRL write with bit0 pulses, for exactly one cycle.
        drive(0, 1, 16'h0B, 2'd0, 9'h0, 64'h1, 0, 1, 64'h0);
        @(negedge pClk);
        idle();
        @(negedge pClk);
        check("no_pulse_high_dw", 64'(start_pulse), 64'd0);
        drive(0, 1, 16'h0A, 2'd1, 9'h0, 64'h1, 0, 1, 64'h0);
        @(negedge pClk);
        check("pulse_cycle_n", 64'(start_pulse), 64'd0);
        idle();
        @(negedge pClk);
        check("pulse_cycle_n1", 64'(start_pulse), 64'd1);
        @(negedge pClk);
        check("pulse_cycle_n2", 64'(start_pulse), 64'd0);

        // CYCLE_CNT: two reads exactly 10 cycles apart.
        cap_q.delete();
        drive(1, 0, 16'h08, 2'd1, 9'h0C1, 64'h0, 1, 0, 64'h0);
        repeat (9) idle();
        drive(1, 0, 16'h08, 2'd1, 9'h0C2, 64'h0, 1, 0, 64'h0);
        idle();
        drain();
        check("cycle_cnt_captures", 64'(cap_q.size()), 64'd2);
        if (cap_q.size() == 2) check("cycle_cnt_delta", cap_q[1] - cap_q[0], 64'd10);

        // Reset one cycle after a read: the read must never be answered, state is cleared.
        drive(1, 0, 16'h06, 2'd1, 9'h0AA, 64'h0, 0, 1, 64'h0);
        @(posedge pClk); #1;
        rx_mmio_rd_valid = 1'b0;
        pck_cp2af_softReset = 1'b1;
        drive(1, 0, 16'h06, 2'd1, 9'h0AB, 64'h0, 0, 1, 64'h0);
        idle();
        pck_cp2af_softReset = 1'b0;
        repeat (6) idle();
        check("no_rsp_after_reset", 64'(unexpected), 64'd0);
        drive(1, 0, 16'h06, 2'd1, 9'h0AC, 64'h0, 1, 1, 64'h0);
        drive(1, 0, 16'h0C, 2'd1, 9'h0AD, 64'h0, 1, 1, {32'h0, STAT});
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
